dest_egress_arbiter: RTL and testbench

- Downstream stage of the PCIe transaction top; consumes the D0 and D1 destination FIFOs.
- Issues pops to D0/D1 under weighted round-robin arbitration.
- Captures popped words in a skid buffer and presents one tagged stream to the link layer with a valid/ready handshake.
- Provides an idle indication back to the control FSM.

---
 rtl/dest_egress_arbiter_pkg.sv | 17 +
 rtl/dest_egress_arbiter_skid_buf.sv | 56 +++++
 rtl/dest_egress_arbiter.sv | 151 +++++++++++++++
 tb/tb_dest_egress_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dest_egress_arbiter_pkg.sv
// Shared types and defaults for the destination egress arbiter.
package dest_egress_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE_D0 = 2'd1,
    ST_SERVE_D1 = 2'd2
  } arb_state_e;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int unsigned DEF_DATA_W     = 6;
  localparam int unsigned DEF_BURST      = 4;
  localparam int unsigned DEF_SKID_DEPTH = 2;

endpackage

// File: rtl/dest_egress_arbiter_skid_buf.sv
// Circular skid buffer holding {tag, data} words between the FIFO pops and the link layer.
module egress_skid_buf #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0] occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; contents cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // The pop-side space check must keep the buffer from ever overfilling.
  occ_bound_a : assert property (@(posedge clk) disable iff (reset) occ <= OCC_W'(DEPTH));

endmodule

// File: rtl/dest_egress_arbiter.sv
// Weighted round-robin egress arbiter draining the D0/D1 destination FIFOs into one
// tagged valid/ready stream. Optional per-tag dequeue counters: define EGRESS_STATS_EN.
module dest_egress_arbiter
  import dest_egress_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BURST      = DEF_BURST,
  parameter int unsigned SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_d0,
  input  logic              fifo_empty_d1,
  input  logic [DATA_W-1:0] data_d0,
  input  logic [DATA_W-1:0] data_d1,
  output logic              pop_d0,
  output logic              pop_d1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              egress_idle
`ifdef EGRESS_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [7:0]        stat_cnt_d0,
  output logic [7:0]        stat_cnt_d1
`endif
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);
  localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inflight_q, inflight_tag_q;
  logic [OCC_W-1:0] occ, occ_next;
  logic             deq, space, serve_d1, own_empty, other_empty;
  logic             pop_own, pop_other, pop_any;
  logic [DATA_W:0]  wr_word, rd_word;

  assign serve_d1    = (state_q == ST_SERVE_D1);
  assign own_empty   = serve_d1 ? fifo_empty_d1 : fifo_empty_d0;
  assign other_empty = serve_d1 ? fifo_empty_d0 : fifo_empty_d1;
  assign deq         = out_valid & out_ready;
  // Words already held or in flight, minus the one leaving this cycle, must leave a free slot.
  assign space       = (SUM_W'(occ) + SUM_W'(inflight_q) - SUM_W'(deq)) < SUM_W'(SKID_DEPTH);
  assign pop_d0      = (pop_own & ~serve_d1) | (pop_other & serve_d1);
  assign pop_d1      = (pop_own & serve_d1) | (pop_other & ~serve_d1);
  assign pop_any     = pop_d0 | pop_d1;
  assign occ_next    = occ + OCC_W'(inflight_q) - OCC_W'(deq);

  // Arbitration: next state, burst count and pop selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_own   = 1'b0;
    pop_other = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty_d0) begin
          state_d = ST_SERVE_D0;
        end else if (!fifo_empty_d1) begin
          state_d = ST_SERVE_D1;
        end
      end
      ST_SERVE_D0, ST_SERVE_D1: begin
        if (own_empty && other_empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (own_empty) begin
          // Hand over and pop the other side in the same step to avoid a bubble.
          pop_other = space;
          state_d   = serve_d1 ? ST_SERVE_D0 : ST_SERVE_D1;
          cnt_d     = space ? CNT_W'(1) : '0;
        end else if (space) begin
          pop_own = 1'b1;
          if (32'(cnt_q) + 32'd1 >= BURST) begin
            cnt_d = '0;
            if (!other_empty) begin
              state_d = serve_d1 ? ST_SERVE_D0 : ST_SERVE_D1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state, in-flight pop tracking and idle flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= DEST_D0;
      egress_idle    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inflight_q     <= pop_any;
      inflight_tag_q <= pop_d1 ? DEST_D1 : DEST_D0;
      egress_idle    <= (state_d == ST_IDLE) && (occ_next == '0) && !pop_any;
    end
  end

  assign wr_word             = {inflight_tag_q, inflight_tag_q ? data_d1 : data_d0};
  assign {out_dest, out_data} = rd_word;
  assign out_valid           = (occ != '0);

  egress_skid_buf #(
    .WIDTH (DATA_W + 1),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight_q),
    .wr_data (wr_word),
    .rd_en   (deq),
    .rd_data (rd_word),
    .occ     (occ)
  );

`ifdef EGRESS_STATS_EN
  // Saturating per-tag dequeue counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt_d0 <= '0;
      stat_cnt_d1 <= '0;
    end else if (stat_clr) begin
      stat_cnt_d0 <= '0;
      stat_cnt_d1 <= '0;
    end else if (deq) begin
      if (out_dest == DEST_D0 && stat_cnt_d0 != 8'd255) begin
        stat_cnt_d0 <= stat_cnt_d0 + 8'd1;
      end
      if (out_dest == DEST_D1 && stat_cnt_d1 != 8'd255) begin
        stat_cnt_d1 <= stat_cnt_d1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dest_egress_arbiter.sv
// Self-checking bench for dest_egress_arbiter: FIFO models, scoreboard and scenario tasks.
module tb_dest_egress_arbiter;

  localparam int DATA_W = 6;
  localparam int BURST  = 4;

  typedef struct packed {
    logic              tag;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty_d0 = 1'b1;
  logic              fifo_empty_d1 = 1'b1;
  logic [DATA_W-1:0] data_d0 = '0;
  logic [DATA_W-1:0] data_d1 = '0;
  logic              out_ready = 1'b0;
  logic              pop_d0, pop_d1, out_dest, out_valid, egress_idle;
  logic [DATA_W-1:0] out_data;
`ifdef EGRESS_STATS_EN
  logic              stat_clr = 1'b0;
  logic [7:0]        stat_cnt_d0, stat_cnt_d1;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  word_t             exp_q[$];
  word_t             prev_word;
  bit                prev_valid = 1'b0;
  bit                prev_ready = 1'b0;

  always #5 clk = ~clk;

  dest_egress_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty_d0 (fifo_empty_d0),
    .fifo_empty_d1 (fifo_empty_d1),
    .data_d0       (data_d0),
    .data_d1       (data_d1),
    .pop_d0        (pop_d0),
    .pop_d1        (pop_d1),
    .out_data      (out_data),
    .out_dest      (out_dest),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .egress_idle   (egress_idle)
`ifdef EGRESS_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_cnt_d0   (stat_cnt_d0),
    .stat_cnt_d1   (stat_cnt_d1)
`endif
  );

  // Upstream FIFOs: read data appears the cycle after a pop, flags track queue contents.
  always @(posedge clk) begin
    if (pop_d0 && q0.size() > 0) data_d0 <= q0.pop_front();
    if (pop_d1 && q1.size() > 0) data_d1 <= q1.pop_front();
    fifo_empty_d0 <= (q0.size() == 0);
    fifo_empty_d1 <= (q1.size() == 0);
  end

  // Scoreboard: pop legality, output holding and in-order delivery of every word.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      checks++;
      if (pop_d0 && pop_d1) begin
        errors++;
        $display("FAIL dual_pop: pop_d0=%0b pop_d1=%0b, at most one allowed", pop_d0, pop_d1);
      end
      checks++;
      if ((pop_d0 && fifo_empty_d0) || (pop_d1 && fifo_empty_d1)) begin
        errors++;
        $display("FAIL pop_on_empty: pop_d0=%0b empty0=%0b pop_d1=%0b empty1=%0b",
                 pop_d0, fifo_empty_d0, pop_d1, fifo_empty_d1);
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!out_valid || {out_dest, out_data} !== prev_word) begin
          errors++;
          $display("FAIL hold: got valid=%0b word=%h, required valid=1 word=%h",
                   out_valid, {out_dest, out_data}, prev_word);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no word", {out_dest, out_data});
        end else begin
          if ({out_dest, out_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL order: got tag=%0b data=%h, required tag=%0b data=%h",
                     out_dest, out_data, exp_q[0].tag, exp_q[0].data);
          end
          exp_q.delete(0);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_word  = {out_dest, out_data};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Preload both FIFOs together and derive the delivery order from the burst rule:
  // alternate chunks of up to BURST words starting at D0; once one side is exhausted the
  // other drains completely.
  task automatic load_pair(input int n0, input int n1);
    logic [DATA_W-1:0] w0[$];
    logic [DATA_W-1:0] w1[$];
    logic [DATA_W-1:0] w;
    int r0, r1, rc, ro, take;
    bit cur;
    for (int i = 0; i < n0; i++) begin
      w = DATA_W'($urandom); q0.push_back(w); w0.push_back(w);
    end
    for (int i = 0; i < n1; i++) begin
      w = DATA_W'($urandom); q1.push_back(w); w1.push_back(w);
    end
    r0 = n0; r1 = n1; cur = (n0 == 0);
    while (r0 + r1 > 0) begin
      rc = cur ? r1 : r0;
      ro = cur ? r0 : r1;
      if (rc == 0) begin
        cur = !cur;
        continue;
      end
      take = (ro == 0) ? rc : ((rc < BURST) ? rc : BURST);
      for (int i = 0; i < take; i++) begin
        if (cur) exp_q.push_back({1'b1, w1.pop_front()});
        else     exp_q.push_back({1'b0, w0.pop_front()});
      end
      if (cur) r1 -= take; else r0 -= take;
      cur = !cur;
    end
  endtask

  task automatic load_d0(input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DATA_W'($urandom); q0.push_back(w); exp_q.push_back({1'b0, w});
    end
  endtask

  // Run until everything loaded has been delivered and the block is idle; used = -1 on timeout.
  task automatic drain(input int budget, input int ready_pct, output int used);
    used = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (egress_idle && exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        used = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pop_d0 !== 1'b0 || pop_d1 !== 1'b0 || egress_idle !== 1'b1 ||
        out_data !== '0 || out_dest !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%0b pop=%0b%0b idle=%0b data=%h dest=%0b, required 0 00 1 00 0",
               out_valid, pop_d0, pop_d1, egress_idle, out_data, out_dest);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    load_d0(4);
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: got out_valid=%0b, required 1", out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pop_d0 !== 1'b0 || pop_d1 !== 1'b0 || egress_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstream: valid=%0b pop=%0b%0b idle=%0b, required 0 00 1",
               out_valid, pop_d0, pop_d1, egress_idle);
    end
    q0.delete(); q1.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_word: got out_valid=%0b data=%h, required 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_single_source();
    bit found = 1'b0;
    int used;
    logic exp_pop, exp_valid;
    @(posedge clk); #1;
    out_ready = 1'b1;
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07);
    exp_q.push_back({1'b0, 6'h05}); exp_q.push_back({1'b0, 6'h06}); exp_q.push_back({1'b0, 6'h07});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop_d0) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL single_first_pop: got no pop_d0 in 20 cycles, required a pop");
    end else begin
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        exp_pop   = (k < 3);
        exp_valid = (k >= 2 && k < 5);
        checks++;
        if (pop_d0 !== exp_pop) begin
          errors++;
          $display("FAIL single_pop t+%0d: got %0b, required %0b", k, pop_d0, exp_pop);
        end
        checks++;
        if (out_valid !== exp_valid) begin
          errors++;
          $display("FAIL single_valid t+%0d: got %0b, required %0b", k, out_valid, exp_valid);
        end
        if (exp_valid) begin
          checks++;
          if (out_data !== DATA_W'(3 + k) || out_dest !== 1'b0) begin
            errors++;
            $display("FAIL single_data t+%0d: got %h/%0b, required %h/0", k, out_data, out_dest,
                     DATA_W'(3 + k));
          end
        end
      end
    end
    drain(50, 100, used);
    checks++;
    if (used < 0 || egress_idle !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: got idle=%0b used=%0d, required idle=1", egress_idle, used);
    end
  endtask

  task automatic test_round_robin();
    bit found = 1'b0;
    int run = 0;
    int used;
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_pair(10, 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    if (found) begin
      run = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) run++;
        else break;
      end
    end
    checks++;
    if (run != 20) begin
      errors++;
      $display("FAIL rr_no_bubble: got %0d consecutive words, required 20", run);
    end
    drain(60, 100, used);
    checks++;
    if (used < 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d words outstanding used=%0d, required 0", exp_q.size(), used);
    end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int used;
    word_t head;
    @(posedge clk); #1;
    out_ready = 1'b0;
    load_d0(5);
    head = exp_q[0];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pop_d0) pops++;
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops, required 2", pops);
    end
    checks++;
    if (out_valid !== 1'b1 || {out_dest, out_data} !== head) begin
      errors++;
      $display("FAIL bp_head: got valid=%0b word=%h, required valid=1 word=%h",
               out_valid, {out_dest, out_data}, head);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stream word %0d: got out_valid=%0b, required 1", k, out_valid);
      end
    end
    drain(40, 100, used);
    checks++;
    if (used < 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_empty_boundary();
    bit found = 1'b0;
    int used;
    logic [DATA_W-1:0] w;
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = DATA_W'($urandom);
    q1.push_back(w); exp_q.push_back({1'b1, w});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop_d1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL eb_first_pop: got no pop_d1 in 20 cycles, required a pop");
    end else begin
      load_d0(3);
      @(negedge clk);
      checks++;
      if (pop_d0 !== 1'b1 || pop_d1 !== 1'b0) begin
        errors++;
        $display("FAIL eb_switch: got pop_d0=%0b pop_d1=%0b, required 1 0", pop_d0, pop_d1);
      end
    end
    drain(40, 100, used);
    checks++;
    if (used < 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL eb_drain: got %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int n0, n1, pct, used;
    for (int it = 0; it < 6; it++) begin
      n0  = int'($urandom_range(12));
      n1  = int'($urandom_range(12));
      pct = int'($urandom_range(100, 30));
      @(posedge clk); #1;
      load_pair(n0, n1);
      drain(600, pct, used);
      checks++;
      if (used < 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_%0d (n0=%0d n1=%0d): got %0d outstanding, required 0",
                 it, n0, n1, exp_q.size());
      end
    end
  endtask

`ifdef EGRESS_STATS_EN
  task automatic test_stats();
    int used;
    @(posedge clk); #1; stat_clr = 1'b1;
    @(posedge clk); #1; stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_cnt_d0 !== 8'd0 || stat_cnt_d1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear0: got %0d/%0d, required 0/0", stat_cnt_d0, stat_cnt_d1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_d0(300);
    drain(1000, 100, used);
    checks++;
    if (used < 0 || stat_cnt_d0 !== 8'd255 || stat_cnt_d1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_sat: got %0d/%0d used=%0d, required 255/0", stat_cnt_d0, stat_cnt_d1, used);
    end
    @(posedge clk); #1; stat_clr = 1'b1;
    @(posedge clk); #1; stat_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (stat_cnt_d0 !== 8'd0 || stat_cnt_d1 !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear1: got %0d/%0d, required 0/0", stat_cnt_d0, stat_cnt_d1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_empty_boundary();
    test_random();
`ifdef EGRESS_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
